// File: rtl/fetch_decode_skid.sv
// -----------------------------------------------------------------------------
// fetch_decode_skid
//
// IF1 -> decode pipeline register with an elastic valid/ready handshake and a
// two-entry skid buffer. One fetch group (PC, LANES instructions, per-lane
// valid mask and fetch exception information) is held per entry.
//
// MAIN drives the out_* ports directly. SKID takes the overflow group that
// arrives in the cycle when decode stalls. in_ready and out_valid are
// registers derived from the next occupancy. This means out_ready has no
// combinational path to in_ready.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   flush                 drop every held group and the group offered now
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   in_pc, in_inst        group PC and instructions (lane 0 in the low word)
//   in_mask               per-lane valid
//   in_excp, in_ecode     fetch exception flag and code
//   out_valid / out_ready downstream handshake
//   out_pc .. out_ecode   payload of MAIN
//   occupancy             number of held groups (0..2)
// -----------------------------------------------------------------------------
module fetch_decode_skid #(
    parameter int              WORD    = 32,
    parameter int              LANES   = 1,
    parameter int              ECODE_W = 6,
    parameter logic [WORD-1:0] PC_RST  = 32'h1c00_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD-1:0]       in_pc,
    input  logic [LANES*WORD-1:0] in_inst,
    input  logic [LANES-1:0]      in_mask,
    input  logic                  in_excp,
    input  logic [ECODE_W-1:0]    in_ecode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD-1:0]       out_pc,
    output logic [LANES*WORD-1:0] out_inst,
    output logic [LANES-1:0]      out_mask,
    output logic                  out_excp,
    output logic [ECODE_W-1:0]    out_ecode,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [WORD-1:0]       pc;
        logic [LANES*WORD-1:0] inst;
        logic [LANES-1:0]      mask;
        logic                  excp;
        logic [ECODE_W-1:0]    ecode;
    } entry_t;

    // The state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam entry_t ENTRY_RST = '{
        pc:    PC_RST,
        inst:  '0,
        mask:  '0,
        excp:  1'b0,
        ecode: '0
    };

    // Build the stored form of an incoming group. An excepting group is
    // reduced to lane 0 only, so decode raises the exception exactly once.
    function automatic entry_t capture(
        input logic [WORD-1:0]       pc,
        input logic [LANES*WORD-1:0] inst,
        input logic [LANES-1:0]      mask,
        input logic                  excp,
        input logic [ECODE_W-1:0]    ecode
    );
        entry_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.mask  = excp ? LANES'(1'b1) : mask;
        e.excp  = excp;
        e.ecode = ecode;
        return e;
    endfunction

    state_t state_r;
    state_t state_nxt_s;
    entry_t main_r;
    entry_t main_nxt_s;
    entry_t skid_r;
    entry_t skid_nxt_s;
    entry_t in_entry_s;
    logic   in_ready_r;
    logic   out_valid_r;
    logic   acc_s;
    logic   store_s;
    logic   deq_s;

    assign in_entry_s = capture(in_pc, in_inst, in_mask, in_excp, in_ecode);

    // A bubble (no live lane, no exception) completes the handshake but is
    // not stored.
    assign acc_s   = in_valid & in_ready_r;
    assign store_s = acc_s & (in_excp | (|in_mask));
    assign deq_s   = out_valid_r & out_ready;

    // Next-state and entry update for the EMPTY/ONE/FULL occupancy machine.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (store_s) begin
                    state_nxt_s = ST_ONE;
                    main_nxt_s  = in_entry_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (store_s && !deq_s) begin
                    state_nxt_s = ST_FULL;
                    skid_nxt_s  = in_entry_s;
                end else if (!store_s && deq_s) begin
                    state_nxt_s = ST_EMPTY;
                end else if (store_s && deq_s) begin
                    state_nxt_s = ST_ONE;
                    main_nxt_s  = in_entry_s;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (deq_s) begin
                    state_nxt_s = ST_ONE;
                    main_nxt_s  = skid_r;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                main_nxt_s  = ENTRY_RST;
                skid_nxt_s  = ENTRY_RST;
            end
        endcase
    end

    // State, entry and handshake registers. rst and flush share one clearing
    // path. The group offered in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r     <= ST_EMPTY;
            main_r      <= ENTRY_RST;
            skid_r      <= ENTRY_RST;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pc    = main_r.pc;
    assign out_inst  = main_r.inst;
    assign out_mask  = main_r.mask;
    assign out_excp  = main_r.excp;
    assign out_ecode = main_r.ecode;
    assign occupancy = state_r;

endmodule

// File: tb/tb_fetch_decode_skid.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_skid
//
// Directed bench for fetch_decode_skid with LANES = 2. Stimulus pushes the
// expected group into a queue whenever it offers a group that must survive.
// A monitor pops from the queue and compares the group whenever the DUT
// completes an output handshake. The main thread also checks occupancy,
// in_ready and reset/flush values at chosen cycles.
// -----------------------------------------------------------------------------
module tb_fetch_decode_skid;

    localparam int          WORD    = 32;
    localparam int          LANES   = 2;
    localparam int          ECODE_W = 6;
    localparam logic [31:0] PC_RST  = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
        logic        excp;
        logic [5:0]  ecode;
    } grp_t;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD-1:0]       in_pc;
    logic [LANES*WORD-1:0] in_inst;
    logic [LANES-1:0]      in_mask;
    logic                  in_excp;
    logic [ECODE_W-1:0]    in_ecode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD-1:0]       out_pc;
    logic [LANES*WORD-1:0] out_inst;
    logic [LANES-1:0]      out_mask;
    logic                  out_excp;
    logic [ECODE_W-1:0]    out_ecode;
    logic [1:0]            occupancy;

    grp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_decode_skid #(
        .WORD    (WORD),
        .LANES   (LANES),
        .ECODE_W (ECODE_W),
        .PC_RST  (PC_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_mask   (in_mask),
        .in_excp   (in_excp),
        .in_ecode  (in_ecode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_mask  (out_mask),
        .out_excp  (out_excp),
        .out_ecode (out_ecode),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge, where outputs are sampled.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [63:0] inst,
                         input logic [1:0] mask, input logic excp, input logic [5:0] ec);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_mask  = mask;
        in_excp  = excp;
        in_ecode = ec;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_pc    = 32'h0;
        in_inst  = 64'h0;
        in_mask  = 2'b00;
        in_excp  = 1'b0;
        in_ecode = 6'h00;
    endtask

    task automatic expect_grp(input logic [31:0] pc, input logic [63:0] inst,
                              input logic [1:0] mask, input logic excp, input logic [5:0] ec);
        grp_t g;
        g.pc    = pc;
        g.inst  = inst;
        g.mask  = mask;
        g.excp  = excp;
        g.ecode = ec;
        exp_q.push_back(g);
    endtask

    // Check the cleared state that must follow a reset or a flush.
    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_pc"},    64'(out_pc),    64'(PC_RST));
        chk({tag, "_out_inst"},  out_inst,       64'd0);
        chk({tag, "_out_mask"},  64'(out_mask),  64'd0);
        chk({tag, "_out_excp"},  64'(out_excp),  64'd0);
        chk({tag, "_out_ecode"}, 64'(out_ecode), 64'd0);
    endtask

    // Fill both entries, offer C while FULL, then kill it with rst and/or flush.
    task automatic kill_full(input logic use_rst, input logic use_flush, input string tag);
        out_ready = 1'b0;
        step();
        drive(32'h2000_0000, 64'h1111_1111_2222_2222, 2'b11, 1'b0, 6'h00);
        step();
        drive(32'h2000_0008, 64'h3333_3333_4444_4444, 2'b11, 1'b0, 6'h00);
        step();
        drive(32'h2000_0010, 64'h5555_5555_6666_6666, 2'b11, 1'b0, 6'h00);
        rst   = use_rst;
        flush = use_flush;
        sample();
        chk({tag, "_occ_full"},     64'(occupancy), 64'd2);
        chk({tag, "_in_ready_low"}, 64'(in_ready),  64'd0);
        step();
        rst   = 1'b0;
        flush = 1'b0;
        idle();
        sample();
        chk_cleared(tag);
        // Drain: no group from before the kill may emerge.
        step();
        out_ready = 1'b1;
        step();
        step();
        sample();
        chk({tag, "_stays_empty"}, 64'(occupancy), 64'd0);
    endtask

    // Scoreboard monitor: every completed output handshake must match the
    // oldest outstanding expected group.
    always @(negedge clk) begin
        grp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_group: got pc %0h expected no group", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("mon_pc",    64'(out_pc),    64'(e.pc));
                chk("mon_inst",  out_inst,       e.inst);
                chk("mon_mask",  64'(out_mask),  64'(e.mask));
                chk("mon_excp",  64'(out_excp),  64'(e.excp));
                chk("mon_ecode", 64'(out_ecode), 64'(e.ecode));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset, then idle.
        step();
        step();
        rst = 1'b0;
        sample();
        chk_cleared("reset");

        // out_ready while EMPTY has no effect.
        step();
        out_ready = 1'b1;
        step();
        sample();
        chk("empty_ready_occ",   64'(occupancy), 64'd0);
        chk("empty_ready_valid", 64'(out_valid), 64'd0);

        // Streaming at one group per cycle. Each group shows one cycle later.
        step();
        drive(32'h1c00_0000, 64'hAAAA_0001_0000_0013, 2'b11, 1'b0, 6'h00);
        expect_grp(32'h1c00_0000, 64'hAAAA_0001_0000_0013, 2'b11, 1'b0, 6'h00);
        step();
        drive(32'h1c00_0008, 64'hAAAA_0002_0000_0093, 2'b01, 1'b0, 6'h00);
        expect_grp(32'h1c00_0008, 64'hAAAA_0002_0000_0093, 2'b01, 1'b0, 6'h00);
        sample();
        chk("stream0_pc",  64'(out_pc),    64'h1c00_0000);
        chk("stream0_occ", 64'(occupancy), 64'd1);
        step();
        drive(32'h1c00_0010, 64'hAAAA_0003_0000_0113, 2'b11, 1'b0, 6'h00);
        expect_grp(32'h1c00_0010, 64'hAAAA_0003_0000_0113, 2'b11, 1'b0, 6'h00);
        sample();
        chk("stream1_pc",  64'(out_pc),    64'h1c00_0008);
        chk("stream1_occ", 64'(occupancy), 64'd1);
        step();
        idle();
        sample();
        chk("stream2_pc",  64'(out_pc),    64'h1c00_0010);
        chk("stream2_occ", 64'(occupancy), 64'd1);
        step();
        sample();
        chk("stream_end_valid", 64'(out_valid), 64'd0);

        // Backpressure: A goes into MAIN and B into SKID, then drain in order.
        out_ready = 1'b0;
        step();
        drive(32'h1c00_0100, 64'hBBBB_0000_0000_000A, 2'b11, 1'b0, 6'h00);
        expect_grp(32'h1c00_0100, 64'hBBBB_0000_0000_000A, 2'b11, 1'b0, 6'h00);
        step();
        drive(32'h1c00_0108, 64'hBBBB_0000_0000_000B, 2'b10, 1'b0, 6'h00);
        expect_grp(32'h1c00_0108, 64'hBBBB_0000_0000_000B, 2'b10, 1'b0, 6'h00);
        sample();
        chk("bp_one_occ",      64'(occupancy), 64'd1);
        chk("bp_one_in_ready", 64'(in_ready),  64'd1);
        step();
        idle();
        sample();
        chk("bp_full_occ",      64'(occupancy), 64'd2);
        chk("bp_full_in_ready", 64'(in_ready),  64'd0);
        chk("bp_full_pc",       64'(out_pc),    64'h1c00_0100);
        step();
        sample();
        chk("bp_stable_pc", 64'(out_pc), 64'h1c00_0100);
        step();
        out_ready = 1'b1;
        sample();
        chk("bp_deq_in_ready", 64'(in_ready), 64'd0);
        step();
        sample();
        chk("bp_recover_in_ready", 64'(in_ready),  64'd1);
        chk("bp_recover_occ",      64'(occupancy), 64'd1);
        chk("bp_recover_pc",       64'(out_pc),    64'h1c00_0108);
        step();
        sample();
        chk("bp_drained_occ", 64'(occupancy), 64'd0);

        // Flush while FULL with C offered.
        kill_full(1'b0, 1'b1, "flush_full");

        // Flush while ONE, with F offered and in_ready high: F is dropped.
        out_ready = 1'b0;
        step();
        drive(32'h3000_0000, 64'h7777_7777_8888_8888, 2'b11, 1'b0, 6'h00);
        step();
        drive(32'h3000_0008, 64'h9999_9999_AAAA_AAAA, 2'b11, 1'b0, 6'h00);
        flush = 1'b1;
        sample();
        chk("flush_one_in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        idle();
        sample();
        chk_cleared("flush_one");
        out_ready = 1'b1;
        step();
        step();

        // Bubble: the handshake completes but nothing is stored.
        step();
        drive(32'h1c00_0200, 64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1'b0, 6'h00);
        sample();
        chk("bubble_in_ready", 64'(in_ready), 64'd1);
        step();
        idle();
        sample();
        chk("bubble_valid", 64'(out_valid), 64'd0);
        chk("bubble_occ",   64'(occupancy), 64'd0);

        // Exception groups: the mask is forced to lane 0 only.
        step();
        drive(32'h1c00_0300, 64'hCAFE_0000_0000_0001, 2'b10, 1'b1, 6'h08);
        expect_grp(32'h1c00_0300, 64'hCAFE_0000_0000_0001, 2'b01, 1'b1, 6'h08);
        step();
        drive(32'h1c00_0308, 64'hCAFE_0000_0000_0002, 2'b00, 1'b1, 6'h2a);
        expect_grp(32'h1c00_0308, 64'hCAFE_0000_0000_0002, 2'b01, 1'b1, 6'h2a);
        step();
        idle();
        step();
        sample();
        chk("excp_drained_occ", 64'(occupancy), 64'd0);

        // Mid-stream reset while FULL, then reset and flush together.
        kill_full(1'b1, 1'b0, "rst_full");
        kill_full(1'b1, 1'b1, "rst_flush_full");

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_skid.md
# fetch_decode_skid

Parametrised IF→ID pipeline stage with an elastic valid/ready handshake and a 2-entry skid buffer. It carries a fetch group of LANES instructions plus PC, a per-lane valid mask and fetch-exception info. Flush and backpressure are decoupled: in_ready is registered, so stall paths stay short. It sits between the fetch stage (IF1) and the decoder.

## Interface
- WORD, 32, datapath / PC width
- LANES, 1, instructions per fetch group (1, 2 or 4)
- ECODE_W, 6, exception code width
- PC_RST, 32'h1c00_0000, PC value held in both entries after reset/flush
---
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming content
- in_valid  in  1  upstream group valid
- in_ready  out  1  stage can accept (registered)
- in_pc  in  WORD  group PC
- in_inst  in  LANES*WORD  instructions, lane 0 in bits [WORD-1:0]
- in_mask  in  LANES  per-lane valid
- in_excp  in  1  fetch exception on this group
- in_ecode  in  ECODE_W  exception code
- out_valid  out  1  group presented to decode
- out_ready  in  1  decode accepts
- out_pc, out_inst, out_mask, out_excp, out_ecode  out  same widths as inputs
- occupancy  out  2  entries held (0..2)

## Operation
- Two entries: MAIN drives the out_* ports; SKID holds overflow. State = occupancy: EMPTY(0), ONE(1), FULL(2).
- acc = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = (occupancy != 2). out_valid = (occupancy != 0).
- Bubble filter: a group with in_mask == 0 and in_excp == 0 completes the handshake (acc = 1) but is not stored; state treats it as no input.
- Exception groups: when in_excp = 1, the stored mask is forced to 1 (lane 0 only), regardless of in_mask. Stored inst and ecode are unchanged. Groups with excp = 1 and in_mask == 0 are stored.
- Transitions (store = acc and not a bubble):
  - EMPTY: store → ONE, input loaded into MAIN.
  - ONE, store & !deq → FULL, input loaded into SKID.
  - ONE, !store & deq → EMPTY.
  - ONE, store & deq → ONE, input loaded into MAIN.
  - ONE, neither → hold.
  - FULL: deq → ONE, MAIN ← SKID. Otherwise hold. (No input is possible while FULL.)
- Priority: rst > flush > normal.
- rst or flush: next state EMPTY. Both entries are set to pc = PC_RST, inst = 0, mask = 0, excp = 0, ecode = 0. A group offered in the flush cycle is dropped, even though in_ready may be 1.
- Ordering: groups leave in arrival order. The payload on out_* is stable while out_valid & !out_ready.
- LANES = 1 degenerates to a single-instruction stage with a 1-bit mask.

## Timing
- Reset values: in_ready = 1, out_valid = 0, occupancy = 0, out_pc = PC_RST, out_inst = 0, out_mask = 0, out_excp = 0, out_ecode = 0.
- Latency: a group accepted at edge N is on out_* with out_valid = 1 after edge N.
- Throughput: 1 group/cycle with out_ready held at 1. Occupancy oscillates between 1 and 1 and never reaches 2.
- Backpressure: with out_ready = 0, a second group is accepted into SKID. in_ready falls in the cycle after that acceptance. No third group is ever accepted.
- Recovery: from FULL, one deq sets in_ready = 1 on the next cycle, and SKID's group appears on out_*.
- Flush mid-operation (any state): out_valid = 0 and in_ready = 1 in the cycle after the flush edge.
- out_ready while EMPTY has no effect.
- No combinational path from out_ready to in_ready.

## Test plan
- Reset then idle: after rst, out_valid = 0, in_ready = 1, out_pc = 32'h1c00_0000, occupancy = 0.
- Streaming: LANES = 2, out_ready = 1, groups at PC 0x1c000000, 0x1c000008, 0x1c000010 on consecutive cycles. Each appears exactly 1 cycle later, occupancy = 1 throughout, and nothing is dropped or duplicated.
- Backpressure: out_ready = 0, send A then B. Occupancy goes to 2 and in_ready = 0. Raise out_ready; A then B appear in order, and in_ready returns to 1 one cycle after A leaves.
- Flush while FULL with C offered: the next cycle shows out_valid = 0, occupancy = 0, out_pc = PC_RST, in_ready = 1. C never appears.
- Bubble and exception:
  - in_mask = 0, excp = 0 → handshake completes, nothing is output.
  - in_mask = 2'b10, excp = 1, ecode = 6'h08 → output mask = 2'b01, excp = 1, ecode = 6'h08.
- Mid-stream rst while occupancy = 2: behaviour is identical to the flush case. It also applies when flush is asserted together with rst.
